// File: rtl/dual_ram_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between req0 (load/store) and req1 (debug/loader).
// Define RAM_ARB_CLR_INIT_EN to sweep the RAM to zero after reset before accepting traffic.
module dual_ram_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 12,
    parameter int MEM_NUM = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid_i,
    input  logic          req0_we_i,
    input  logic [AW-1:0] req0_addr_i,
    input  logic [DW-1:0] req0_wdata_i,
    output logic          req0_ready_o,
    output logic          req0_rvalid_o,
    output logic [DW-1:0] req0_rdata_o,
    input  logic          req1_valid_i,
    input  logic          req1_we_i,
    input  logic [AW-1:0] req1_addr_i,
    input  logic [DW-1:0] req1_wdata_i,
    output logic          req1_ready_o,
    output logic          req1_rvalid_o,
    output logic [DW-1:0] req1_rdata_o,
    output logic          ram_w_en_o,
    output logic [AW-1:0] ram_w_addr_o,
    output logic [DW-1:0] ram_w_data_o,
    output logic          ram_r_en_o,
    output logic [AW-1:0] ram_r_addr_o,
    input  logic [DW-1:0] ram_r_data_i,
    output logic          init_done_o
);

    logic          last_grant_q, last_grant_d;
    logic          resp_owner_q, resp_owner_d;
    logic          rvalid_q, rvalid_d;
    logic          run;
    logic          in_init;
    logic [AW-1:0] sweep_addr;
    logic          grant0, grant1, any_grant;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

`ifdef RAM_ARB_CLR_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sweep writes one word per cycle and leaves INIT after the last address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(MEM_NUM - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    assign in_init     = !rst && (state_q == ST_INIT);
    assign run         = !rst && (state_q == ST_RUN);
    assign sweep_addr  = cnt_q;
    assign init_done_o = (state_q == ST_RUN);
`else
    // Without the sweep the depth is irrelevant to the logic.
    logic [31:0] unused_mem_num;

    assign unused_mem_num = MEM_NUM;
    assign in_init        = 1'b0;
    assign run            = !rst;
    assign sweep_addr     = '0;
    assign init_done_o    = !rst;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            resp_owner_q <= 1'b0;
            rvalid_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            resp_owner_q <= resp_owner_d;
            rvalid_q     <= rvalid_d;
        end
    end

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (run) begin
            if (req0_valid_i && req1_valid_i) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = req0_valid_i;
                grant1 = req1_valid_i;
            end
        end
        any_grant = grant0 | grant1;

        sel_we    = grant1 ? req1_we_i    : req0_we_i;
        sel_addr  = grant1 ? req1_addr_i  : req0_addr_i;
        sel_wdata = grant1 ? req1_wdata_i : req0_wdata_i;

        last_grant_d = any_grant ? grant1 : last_grant_q;
        rvalid_d     = any_grant && !sel_we;
        resp_owner_d = rvalid_d ? grant1 : resp_owner_q;
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    assign ram_w_en_o   = in_init || (any_grant && sel_we);
    assign ram_w_addr_o = in_init ? sweep_addr : sel_addr;
    assign ram_w_data_o = in_init ? '0 : sel_wdata;
    assign ram_r_en_o   = any_grant && !sel_we;
    assign ram_r_addr_o = sel_addr;

    // Read data returns one cycle late and goes only to the requester that issued it.
    assign req0_rvalid_o = rvalid_q && !resp_owner_q;
    assign req1_rvalid_o = rvalid_q && resp_owner_q;
    assign req0_rdata_o  = req0_rvalid_o ? ram_r_data_i : '0;
    assign req1_rdata_o  = req1_rvalid_o ? ram_r_data_i : '0;

endmodule

// File: tb/tb_dual_ram_arbiter.sv
// Bench for dual_ram_arbiter: a behavioural RAM plus a memory/arbitration reference model.
module tb_dual_ram_arbiter;

    localparam int DW      = 32;
    localparam int AW      = 12;
    localparam int MEM_NUM = 16;
    localparam int DEPTH   = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ready, req0_rvalid, req1_ready, req1_rvalid;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          ram_w_en, ram_r_en, init_done;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic [DW-1:0] ram_w_data, ram_r_data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram       [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];
    int            exp_last;

    dual_ram_arbiter #(.DW(DW), .AW(AW), .MEM_NUM(MEM_NUM)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid), .req0_we_i(req0_we), .req0_addr_i(req0_addr),
        .req0_wdata_i(req0_wdata), .req0_ready_o(req0_ready), .req0_rvalid_o(req0_rvalid),
        .req0_rdata_o(req0_rdata),
        .req1_valid_i(req1_valid), .req1_we_i(req1_we), .req1_addr_i(req1_addr),
        .req1_wdata_i(req1_wdata), .req1_ready_o(req1_ready), .req1_rvalid_o(req1_rvalid),
        .req1_rdata_o(req1_rdata),
        .ram_w_en_o(ram_w_en), .ram_w_addr_o(ram_w_addr), .ram_w_data_o(ram_w_data),
        .ram_r_en_o(ram_r_en), .ram_r_addr_o(ram_r_addr), .ram_r_data_i(ram_r_data),
        .init_done_o(init_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fill(int a);
        return (32'(a) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    endfunction

    // Synchronous RAM: write lands at the edge, read data appears after the edge.
    initial begin : ram_proc
        for (int a = 0; a < DEPTH; a++) ram[a] <= fill(a);
        ram_r_data <= '0;
        forever begin
            @(posedge clk);
            if (ram_w_en) ram[ram_w_addr] <= ram_w_data;
            if (ram_r_en) ram_r_data <= ram[ram_r_addr];
        end
    end

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_we = 1'b0;
        req1_valid = 1'b0; req1_we = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'h001;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 12'h002;
        @(negedge clk); #1;
        checks++;
        if ({req0_ready, req1_ready, ram_w_en, ram_r_en, init_done, req0_rvalid, req1_rvalid} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got r0=%b r1=%b wen=%b ren=%b done=%b rv0=%b rv1=%b want all 0",
                     req0_ready, req1_ready, ram_w_en, ram_r_en, init_done, req0_rvalid, req1_rvalid);
        end
        checks++;
        if (req0_rdata !== '0 || req1_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_rdata got %h %h want 0 0", req0_rdata, req1_rdata);
        end
        exp_last = 1;
    endtask

`ifdef RAM_ARB_CLR_INIT_EN
    task automatic test_init_sweep();
        for (int i = 0; i < MEM_NUM; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            req0_valid = 1'b1; req0_we = 1'b0;
            req1_valid = 1'b1; req1_we = 1'b0;
            #1;
            checks++;
            if ({req0_ready, req1_ready, ram_r_en, ram_w_en, init_done} !== 5'b00010 ||
                ram_w_addr !== AW'(i) || ram_w_data !== '0) begin
                errors++;
                $display("[TB] FAIL sweep_cycle%0d got rdy=%b%b ren=%b wen=%b done=%b addr=%h data=%h want rdy=00 ren=0 wen=1 done=0 addr=%h data=0",
                         i, req0_ready, req1_ready, ram_r_en, ram_w_en, init_done, ram_w_addr, ram_w_data, i);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (init_done !== 1'b1 || ram_w_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sweep_done got done=%b wen=%b want done=1 wen=0", init_done, ram_w_en);
        end
    endtask
`else
    task automatic test_no_init();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 12'h020; req1_wdata = 32'h1234_5678;
        #1;
        checks++;
        if ({init_done, req0_ready, req1_ready, ram_w_en, ram_r_en} !== 5'b10110 ||
            ram_w_addr !== 12'h020 || ram_w_data !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL no_init_first_write got done=%b rdy=%b%b wen=%b ren=%b addr=%h data=%h want done=1 rdy=01 wen=1 ren=0 addr=020 data=12345678",
                     init_done, req0_ready, req1_ready, ram_w_en, ram_r_en, ram_w_addr, ram_w_data);
        end
        model_mem[32] = 32'h1234_5678;
        exp_last = 1;
        @(negedge clk);
        idle_inputs();
    endtask
`endif

    task automatic test_write_read();
        @(negedge clk);
        idle_inputs();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 12'h010; req0_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({req0_ready, req1_ready, ram_w_en, ram_r_en, req0_rvalid} !== 5'b10100 ||
            ram_w_addr !== 12'h010 || ram_w_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL wr_grant got rdy=%b%b wen=%b ren=%b rv0=%b addr=%h data=%h want rdy=10 wen=1 ren=0 rv0=0 addr=010 data=deadbeef",
                     req0_ready, req1_ready, ram_w_en, ram_r_en, req0_rvalid, ram_w_addr, ram_w_data);
        end
        model_mem[16] = 32'hDEAD_BEEF;
        @(negedge clk);
        req0_we = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, ram_w_en, ram_r_en} !== 4'b1001 || ram_r_addr !== 12'h010) begin
            errors++;
            $display("[TB] FAIL rd_grant got rdy=%b%b wen=%b ren=%b raddr=%h want rdy=10 wen=0 ren=1 raddr=010",
                     req0_ready, req1_ready, ram_w_en, ram_r_en, ram_r_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (req0_rvalid !== 1'b1 || req0_rdata !== 32'hDEAD_BEEF || req1_rvalid !== 1'b0 || req1_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL rd_response got rv0=%b d0=%h rv1=%b d1=%h want rv0=1 d0=deadbeef rv1=0 d1=0",
                     req0_rvalid, req0_rdata, req1_rvalid, req1_rdata);
        end
        exp_last = 0;
    endtask

    task automatic test_idle_priority();
        logic [DW-1:0] d;
        d = $urandom;
        @(negedge clk);
        idle_inputs();
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 12'h004; req1_wdata = d;
        #1;
        checks++;
        if ({req0_ready, req1_ready, ram_w_en} !== 3'b011 || ram_w_addr !== 12'h004 || ram_w_data !== d) begin
            errors++;
            $display("[TB] FAIL idle_req1_only got rdy=%b%b wen=%b addr=%h data=%h want rdy=01 wen=1 addr=004 data=%h",
                     req0_ready, req1_ready, ram_w_en, ram_w_addr, ram_w_data, d);
        end
        model_mem[4] = d;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({req0_ready, req1_ready, ram_w_en, ram_r_en} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_cycle got rdy=%b%b wen=%b ren=%b want all 0",
                     req0_ready, req1_ready, ram_w_en, ram_r_en);
        end
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 12'h005; req0_wdata = 32'h0000_0505;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 12'h006; req1_wdata = 32'h0000_0606;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10 || ram_w_addr !== 12'h005 || ram_w_data !== 32'h0000_0505) begin
            errors++;
            $display("[TB] FAIL idle_then_tie got rdy=%b%b addr=%h data=%h want rdy=10 addr=005 data=00000505",
                     req0_ready, req1_ready, ram_w_addr, ram_w_data);
        end
        model_mem[5] = 32'h0000_0505;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01 || ram_w_addr !== 12'h006) begin
            errors++;
            $display("[TB] FAIL held_req1 got rdy=%b%b addr=%h want rdy=01 addr=006",
                     req0_ready, req1_ready, ram_w_addr);
        end
        model_mem[6] = 32'h0000_0606;
        exp_last = 1;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_contention();
        logic          rv_exp [2];
        logic [DW-1:0] rd_exp;
        int            g;
        int            prev_g;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            req0_valid = (k < 4); req0_we = 1'b0; req0_addr = 12'h001;
            req1_valid = (k < 4); req1_we = 1'b0; req1_addr = 12'h002;
            #1;
            g = k % 2;
            if (k < 4) begin
                checks++;
                if (req0_ready !== (g == 0) || req1_ready !== (g == 1) || ram_r_en !== 1'b1 ||
                    ram_r_addr !== (g == 1 ? 12'h002 : 12'h001)) begin
                    errors++;
                    $display("[TB] FAIL contention_grant%0d got rdy=%b%b ren=%b raddr=%h want grant to req%0d",
                             k, req0_ready, req1_ready, ram_r_en, ram_r_addr, g);
                end
            end
            if (k > 0) begin
                prev_g     = (k - 1) % 2;
                rv_exp[0]  = (prev_g == 0);
                rv_exp[1]  = (prev_g == 1);
                rd_exp     = model_mem[prev_g + 1];
                checks++;
                if (req0_rvalid !== rv_exp[0] || req1_rvalid !== rv_exp[1] ||
                    (prev_g == 0 ? req0_rdata : req1_rdata) !== rd_exp) begin
                    errors++;
                    $display("[TB] FAIL contention_resp%0d got rv=%b%b d0=%h d1=%h want owner req%0d data=%h",
                             k, req0_rvalid, req1_rvalid, req0_rdata, req1_rdata, prev_g, rd_exp);
                end
            end
        end
        exp_last = 1;
        idle_inputs();
    endtask

    task automatic test_random();
        bit            pv  [2];
        bit            pwe [2];
        logic [AW-1:0] pa  [2];
        logic [DW-1:0] pd  [2];
        bit            pend_v;
        int            pend_owner;
        logic [DW-1:0] pend_data;
        int            g;
        logic          e_r0, e_r1, e_wen, e_ren, e_rv0, e_rv1;
        logic [DW-1:0] e_d0, e_d1;
        pend_v = 1'b0; pend_owner = 0; pend_data = '0;
        for (int r = 0; r < 2; r++) begin
            pv[r] = 1'b0; pwe[r] = 1'b0; pa[r] = '0; pd[r] = '0;
        end
        for (int c = 0; c < 401; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && c < 400 && $urandom_range(0, 99) < 60) begin
                    pv[r]  = 1'b1;
                    pwe[r] = $urandom_range(0, 1) == 1;
                    pa[r]  = AW'($urandom_range(0, 31));
                    pd[r]  = $urandom;
                end
            end
            @(negedge clk);
            req0_valid = pv[0]; req0_we = pwe[0]; req0_addr = pa[0]; req0_wdata = pd[0];
            req1_valid = pv[1]; req1_we = pwe[1]; req1_addr = pa[1]; req1_wdata = pd[1];
            #1;
            if (pv[0] && pv[1]) g = 1 - exp_last;
            else if (pv[0])     g = 0;
            else if (pv[1])     g = 1;
            else                g = -1;
            e_r0  = (g == 0);
            e_r1  = (g == 1);
            e_wen = (g >= 0) && pwe[g];
            e_ren = (g >= 0) && !pwe[g];
            e_rv0 = pend_v && pend_owner == 0;
            e_rv1 = pend_v && pend_owner == 1;
            e_d0  = e_rv0 ? pend_data : '0;
            e_d1  = e_rv1 ? pend_data : '0;
            checks++;
            if ({req0_ready, req1_ready, ram_w_en, ram_r_en, req0_rvalid, req1_rvalid} !==
                {e_r0, e_r1, e_wen, e_ren, e_rv0, e_rv1} || req0_rdata !== e_d0 || req1_rdata !== e_d1) begin
                errors++;
                $display("[TB] FAIL random_c%0d got rdy=%b%b wen=%b ren=%b rv=%b%b d0=%h d1=%h want rdy=%b%b wen=%b ren=%b rv=%b%b d0=%h d1=%h",
                         c, req0_ready, req1_ready, ram_w_en, ram_r_en, req0_rvalid, req1_rvalid, req0_rdata, req1_rdata,
                         e_r0, e_r1, e_wen, e_ren, e_rv0, e_rv1, e_d0, e_d1);
            end
            if (e_wen) begin
                checks++;
                if (ram_w_addr !== pa[g] || ram_w_data !== pd[g]) begin
                    errors++;
                    $display("[TB] FAIL random_wport_c%0d got addr=%h data=%h want addr=%h data=%h",
                             c, ram_w_addr, ram_w_data, pa[g], pd[g]);
                end
            end
            if (e_ren) begin
                checks++;
                if (ram_r_addr !== pa[g]) begin
                    errors++;
                    $display("[TB] FAIL random_rport_c%0d got addr=%h want addr=%h", c, ram_r_addr, pa[g]);
                end
            end
            pend_v = 1'b0;
            if (g >= 0) begin
                if (pwe[g]) begin
                    model_mem[pa[g]] = pd[g];
                end else begin
                    pend_v     = 1'b1;
                    pend_owner = g;
                    pend_data  = model_mem[pa[g]];
                end
                exp_last = g;
                pv[g]    = 1'b0;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] want;
        @(negedge clk);
        idle_inputs();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'h007;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || ram_r_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrd_grant got rdy0=%b ren=%b want 1 1", req0_ready, ram_r_en);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if ({req0_rvalid, req1_rvalid, req0_ready, req1_ready, ram_w_en, ram_r_en, init_done} !== 7'b0 ||
            req0_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL midrd_dropped got rv=%b%b rdy=%b%b wen=%b ren=%b done=%b d0=%h want all 0",
                     req0_rvalid, req1_rvalid, req0_ready, req1_ready, ram_w_en, ram_r_en, init_done, req0_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
`ifdef RAM_ARB_CLR_INIT_EN
        for (int i = 0; i < MEM_NUM; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (ram_w_en !== 1'b1 || ram_w_addr !== AW'(i) || req0_rvalid !== 1'b0 || init_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL resweep_cycle%0d got wen=%b addr=%h rv0=%b done=%b want wen=1 addr=%h rv0=0 done=0",
                         i, ram_w_en, ram_w_addr, req0_rvalid, init_done, i);
            end
        end
        for (int a = 0; a < MEM_NUM; a++) model_mem[a] = '0;
        @(negedge clk);
`endif
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'h003;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 12'h004;
        #1;
        checks++;
        if ({init_done, req0_ready, req1_ready, ram_r_en} !== 4'b1101 || ram_r_addr !== 12'h003) begin
            errors++;
            $display("[TB] FAIL post_reset_tie got done=%b rdy=%b%b ren=%b raddr=%h want done=1 rdy=10 ren=1 raddr=003",
                     init_done, req0_ready, req1_ready, ram_r_en, ram_r_addr);
        end
        want = model_mem[3];
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (req0_rvalid !== 1'b1 || req0_rdata !== want || req1_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_read got rv0=%b d0=%h rv1=%b want rv0=1 d0=%h rv1=0",
                     req0_rvalid, req0_rdata, req1_rvalid, want);
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
`ifdef RAM_ARB_CLR_INIT_EN
            model_mem[a] = (a < MEM_NUM) ? '0 : fill(a);
`else
            model_mem[a] = fill(a);
`endif
        end
        exp_last = 1;
        test_reset();
`ifdef RAM_ARB_CLR_INIT_EN
        test_init_sweep();
`else
        test_no_init();
`endif
        test_write_read();
        test_idle_priority();
        test_contention();
        test_random();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_ram_arbiter.md
Name: dual_ram_arbiter

Overview:
- Shares one dual_ram instance between two requesters: req0, the core load/store unit, and req1, the debug/loader path.
- Grants at most one access per cycle using round-robin arbitration.
- Drives the RAM write and read ports and routes the one-cycle-late read data back to the requester that issued the read.
- Optionally sweeps the RAM to zero after reset before accepting traffic.

Parameters:
- DW, 32, data width; matches the RAM DW.
- AW, 12, address width; matches the RAM AW.
- MEM_NUM, 4096, number of RAM words; the init sweep covers 0..MEM_NUM-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req0_valid_i  in  1  requester 0 access request
- req0_we_i  in  1  1 = write, 0 = read
- req0_addr_i  in  AW  requester 0 address
- req0_wdata_i  in  DW  requester 0 write data
- req0_ready_o  out  1  requester 0 access accepted this cycle
- req0_rvalid_o  out  1  requester 0 read data valid
- req0_rdata_o  out  DW  requester 0 read data
- req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i, req1_ready_o, req1_rvalid_o, req1_rdata_o: same as requester 0, for requester 1
- ram_w_en_o  out  1  RAM write enable
- ram_w_addr_o  out  AW  RAM write address
- ram_w_data_o  out  DW  RAM write data
- ram_r_en_o  out  1  RAM read enable
- ram_r_addr_o  out  AW  RAM read address
- ram_r_data_i  in  DW  RAM read data, valid one cycle after ram_r_en_o
- init_done_o  out  1  high once the block is in RUN

Behaviour:
- Reset values: state = INIT (RUN if the macro is absent); last_grant = 1, so req0 wins the first tie; resp_owner = 0; rvalid outputs 0; init counter 0; init_done_o 0.
- While rst is high, all ram_*_en_o and ready outputs are 0.
- State INIT:
  - ram_w_en_o = 1, ram_w_addr_o = init counter, ram_w_data_o = 0.
  - Both ready outputs 0; ram_r_en_o 0.
  - Counter increments every cycle; at counter == MEM_NUM-1 the state goes to RUN.
  - The sweep takes exactly MEM_NUM cycles.
- State RUN, arbitration (combinational):
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant; last_grant unchanged.
  - last_grant updates on every grant.
- Handshake:
  - reqN_ready_o = granted to N. It is combinational from valid, and always 0 when valid is 0.
  - An access is accepted on a cycle where valid and ready are both 1.
  - A requester holds valid, we, addr and wdata stable until accepted.
- Granted write: ram_w_en_o = 1 with the granter's addr/wdata in the same cycle; no response.
- Granted read:
  - ram_r_en_o = 1 with the granter's addr.
  - resp_owner is registered.
  - Next cycle, reqN_rvalid_o = 1 for that owner only, with reqN_rdata_o = ram_r_data_i.
  - Read throughput is one per cycle; back-to-back reads to alternating requesters are routed correctly.
- Ungranted port enables are 0. Address and data outputs are don't-care but are driven from the granted requester, or from req0 when idle.
- rdata outputs are 0 when the matching rvalid is 0.
- Write-then-read of the same address on consecutive cycles returns the new data, because the RAM write lands at the first edge.
- Reset asserted mid-sweep or mid-read:
  - Everything returns to reset values immediately.
  - A pending rvalid is dropped.
  - The sweep restarts from address 0.
- No state other than INIT and RUN. RUN is terminal until reset.

Optional Feature:
- Macro RAM_ARB_CLR_INIT_EN.
- Defined: INIT sweep as above; init_done_o rises after MEM_NUM cycles.
- Undefined: no counter and no INIT state; reset goes directly to RUN; init_done_o = 1 whenever rst is low; the RAM contents are left untouched.

Test Plan:
- Init sweep (macro defined, MEM_NUM = 16): release rst -> ram_w_en_o high for exactly 16 cycles, addresses 0..15, data 0; init_done_o rises at cycle 16; readies 0 throughout.
- Single write then read: req0 writes 0xDEADBEEF to 0x010, then reads 0x010 -> ready0 on both cycles; req0_rvalid_o = 1 with 0xDEADBEEF one cycle after the read grant; req1_rvalid_o stays 0.
- Contention: both requesters valid for 4 cycles, reading 0x001 (req0) and 0x002 (req1) -> grants alternate 0,1,0,1; each rvalid returns the matching data one cycle after its own grant.
- Idle preserves priority: req1 is granted, then an idle cycle, then both valid -> req0 is granted first.
- Reset mid-read: assert rst in the cycle after a read grant -> rvalid stays 0; the sweep restarts from 0 (macro defined) or the block is immediately ready (macro undefined).
- Macro undefined: release rst -> init_done_o = 1 and req1 write accepted on the first cycle.
